rr_arb_pipe: RTL and testbench
==============================

// Module: rr_arb_pipe
// PURPOSE
//  N-to-1 round-robin arbiter that shares one registered valid/ready pipe stage between NUM_REQ requesters.
//  Sits in front of a shared downstream consumer. Multiplexes requester beats into a single output register, tagged with source index.
//  Fairness: every requester with valid held high is served within NUM_REQ accepted beats.
// PARAMETERS
//  DATA_WIDTH  256  payload width per beat
//  NUM_REQ     4    number of requesters, >=2
//  ID_WIDTH    2    width of source index; must equal clog2(NUM_REQ), checked at elaboration
// PORTS
//  clk             in   1                   single clock, rising edge
//  reset           in   1                   synchronous, active-high
//  req_valid       in   NUM_REQ             per-requester valid; bit i = requester i
//  req_data        in   NUM_REQ*DATA_WIDTH  flat payload; slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready       out  NUM_REQ             per-requester ready; at most one bit high per cycle
//  pipe_out_valid  out  1                   output stage holds a beat
//  pipe_out_data   out  DATA_WIDTH          registered payload
//  pipe_out_id     out  ID_WIDTH            index of the requester that supplied the held beat
//  pipe_out_ready  in   1                   downstream accept
// BEHAVIOUR
//  - Reset state: valid_r=0, ptr=0, data_r/id_r don't-care. Outputs on the cycle after reset: pipe_out_valid=0, req_ready=0 unless a requester is valid.
//  - Stage-accept signal: load = !valid_r || pipe_out_ready. Output is fully pipelined, with no bubble on back-to-back transfers.
//  - Grant (combinational):
//    - Scan from index ptr upward, modulo NUM_REQ.
//    - The first i with req_valid[i]=1 is granted.
//    - gnt_any = |req_valid.
//  - Ready: req_ready[i] = load & gnt[i]. Transfer on requester i occurs when req_valid[i] & req_ready[i].
//  - Stage-register update on load:
//    - valid_r <= gnt_any
//    - data_r <= req_data[gnt_idx]
//    - id_r <= gnt_idx
//  - When !load, the stage register holds. Data and id stay stable while valid=1 and ready=0.
//  - Pointer update:
//    - On a transfer from index g, ptr <= (g+1) mod NUM_REQ. Wrap: g=NUM_REQ-1 gives ptr=0.
//    - With no transfer, ptr holds.
//  - Latency: 1 cycle from accepted request beat to pipe_out_valid.
//  - Throughput: 1 beat/cycle when pipe_out_ready=1.
//  - Grant is not sticky. A requester may drop valid before it is accepted; arbitration re-evaluates every cycle.
//  - Simultaneous pop and push: with valid_r=1 and pipe_out_ready=1, the old beat leaves and the new granted beat loads in the same edge.
//  - Stall: with valid_r=1 and pipe_out_ready=0, all req_ready=0 and ptr is frozen.
//  - Reset mid-operation: the held beat is discarded, valid_r=0 and ptr=0 on the next cycle. No req_ready is asserted during the reset cycle.
//  - Combinational path pipe_out_ready -> req_ready is intentional and matches the existing pipe stages. No path req_valid -> pipe_out_valid.
// STRUCTURE
//  - Shared header: clog2 function, plus the flat-bus slice macro for NUM_REQ*DATA_WIDTH buses.
//  - Sub-module rr_grant: (req, ptr) -> onehot gnt, gnt_idx, gnt_any.
//    - Purely combinational, implemented as a double-width masked priority encode.
//    - Reused later by other schedulers.
//  - Top-level contents: rr_grant instance, payload mux, stage register, ptr register.
// TESTING
//  1. Reset, then req_valid=4'b0000 for 5 cycles
//     -> pipe_out_valid=0, req_ready=0, ptr=0 throughout.
//  2. req_valid=4'b1111 held, pipe_out_ready=1, data_i=i
//     -> outputs ids 0,1,2,3,0,... one per cycle, first valid 1 cycle after the first grant.
//  3. req_valid=4'b1010, ptr=0, ready=1
//     -> ids alternate 1,3,1,3. ptr after id 3 wraps to 0.
//  4. Stall: beat id=2 held with pipe_out_ready=0 for 3 cycles
//     -> data/id stable, req_ready=0, ptr unchanged. Release -> the next grant resumes from 3.
//  5. Requester 0 streams continuously, requester 2 raises valid
//     -> requester 2 is served within 2 accepted beats; no starvation over 100 random cycles.
//  6. Assert reset while valid_r=1 and req_valid=4'b0100
//     -> next cycle pipe_out_valid=0, ptr=0, no transfer counted.

Source files
------------

// File: rtl/rr_arb_pipe_pkg.sv
// Shared definitions for the round-robin arbiter pipe and its grant logic:
// width helper and the flat-bus slice macro used on NUM_REQ*DATA_WIDTH buses.
`ifndef RR_ARB_PIPE_PKG_SV
`define RR_ARB_PIPE_PKG_SV

// Select slice idx of width w out of a flat concatenated bus.
`define RR_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package rr_arb_pipe_pkg;

  localparam int DefDataWidth = 256;
  localparam int DefNumReq    = 4;

  // Ceiling log2; a single requester still needs no index bits.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/rr_arb_pipe_grant.sv
// Round-robin grant: picks the first asserted request at or above ptr,
// wrapping around. The request vector is doubled, with the lower copy
// masked below ptr, so a plain lowest-bit priority encode gives the answer.
module rr_grant
  import rr_arb_pipe_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [ID_WIDTH-1:0] gnt_idx_o,
  output logic                gnt_any_o
);

  logic [NUM_REQ-1:0]   maskedReq;
  logic [2*NUM_REQ-1:0] dblReq;

  // Masked double-width priority encode, lowest set bit wins.
  always_comb begin
    maskedReq = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      maskedReq[i] = req_i[i] && (i >= int'(ptr_i));
    end
    dblReq    = {req_i, maskedReq};
    gnt_any_o = |req_i;
    gnt_idx_o = '0;
    for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
      if (dblReq[i]) begin
        gnt_idx_o = ID_WIDTH'(i % NUM_REQ);
      end
    end
    gnt_o = '0;
    if (gnt_any_o) begin
      gnt_o[gnt_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arb_pipe.sv
// N-to-1 round-robin arbiter feeding one registered valid/ready stage.
// The held beat carries the index of the requester that supplied it.
module rr_arb_pipe
  import rr_arb_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          pipe_out_valid,
  output logic [DATA_WIDTH-1:0]         pipe_out_data,
  output logic [ID_WIDTH-1:0]           pipe_out_id,
  input  logic                          pipe_out_ready
);

  if (ID_WIDTH != clog2(NUM_REQ)) begin : g_bad_id_width
    $error("rr_arb_pipe: ID_WIDTH must equal clog2(NUM_REQ)");
  end
  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("rr_arb_pipe: NUM_REQ must be at least 2");
  end

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic                  load;
  logic                  xfer;
  logic [NUM_REQ-1:0]    gnt;
  logic [ID_WIDTH-1:0]   gntIdx;
  logic                  gntAny;

  rr_grant #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_grant (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gntIdx),
    .gnt_any_o (gntAny)
  );

  // Stage accepts when empty or draining; reset suppresses any handshake.
  always_comb begin
    load      = !valid_q || pipe_out_ready;
    req_ready = (load && !reset) ? gnt : '0;
    xfer      = load && gntAny && !reset;
  end

  // Next stage contents: load the granted beat, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    if (load) begin
      valid_d = gntAny;
      data_d  = `RR_SLICE(req_data, gntIdx, DATA_WIDTH);
      id_d    = gntIdx;
    end
  end

  // Pointer moves just past the requester that transferred, wrapping to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gntIdx == ID_WIDTH'(NUM_REQ-1)) ? '0 : gntIdx + ID_WIDTH'(1);
    end
  end

  // Control state: stage valid flag and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  // Payload and source index; meaningless while valid_q is low.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    id_q   <= id_d;
  end

  assign pipe_out_valid = valid_q;
  assign pipe_out_data  = data_q;
  assign pipe_out_id    = id_q;

endmodule

// File: tb/tb_rr_arb_pipe.sv
// Directed bench for rr_arb_pipe: the stimulus process queues the beat it
// expects to be granted, and a monitor pops and compares on every output
// handshake.
module tb_rr_arb_pipe;

  localparam int DW = 256;
  localparam int NR = 4;
  localparam int IW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_ready;
  logic             pipe_out_valid;
  logic [DW-1:0]    pipe_out_data;
  logic [IW-1:0]    pipe_out_id;
  logic             pipe_out_ready = 1'b0;

  exp_t       sb[$];
  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] phase = 8'h00;

  // Free-running clock.
  always #5 clk = ~clk;

  rr_arb_pipe #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .ID_WIDTH   (IW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .pipe_out_valid (pipe_out_valid),
    .pipe_out_data  (pipe_out_data),
    .pipe_out_id    (pipe_out_id),
    .pipe_out_ready (pipe_out_ready)
  );

  // Payload tagged with the cycle phase and requester index.
  function automatic logic [DW-1:0] mkData(input logic [7:0] ph, input int idx);
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) begin
      d[k*32 +: 32] = {ph, 8'(k), 8'h5A, 8'(idx)};
    end
    return d;
  endfunction

  task automatic checkOutput(input string tag, input string what,
                             input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s.%s got 'h%0h want 'h%0h", tag, what, got, want);
    end
  endtask

  // One cycle: drive inputs, queue the expected granted beat, check handshake.
  task automatic applyStimulus(input logic [NR-1:0] v, input logic rdy, input logic rst,
                               input logic [NR-1:0] expRdy, input logic expValid,
                               input int expId, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    phase          = phase + 8'd1;
    reset          = rst;
    req_valid      = v;
    pipe_out_ready = rdy;
    for (int i = 0; i < NR; i++) begin
      req_data[i*DW +: DW] = mkData(phase, i);
    end
    if (expId >= 0) begin
      e.id   = IW'(expId);
      e.data = mkData(phase, expId);
      sb.push_back(e);
    end
    @(negedge clk);
    checkOutput(tag, "req_ready", 32'(req_ready), 32'(expRdy));
    checkOutput(tag, "out_valid", 32'(pipe_out_valid), 32'(expValid));
  endtask

  // Monitor: every accepted output beat must match the oldest queued beat.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && pipe_out_valid === 1'b1 && pipe_out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_beat got id %0d want none", pipe_out_id);
      end else begin
        e = sb.pop_front();
        compared++;
        if (pipe_out_id !== e.id) begin
          mismatched++;
          $display("[TB] FAIL out_id got %0d want %0d", pipe_out_id, e.id);
        end
        compared++;
        if (pipe_out_data !== e.data) begin
          mismatched++;
          $display("[TB] FAIL out_data got 'h%0h want 'h%0h", pipe_out_data, e.data);
        end
      end
    end
  end

  // Directed sequence with hand-derived grants.
  initial begin
    int waitCycles;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Idle after reset: nothing valid, nothing ready.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "idle");
    end

    // All requesting: ids 0,1,2,3,0 one per cycle.
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, 0, "all0");
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 1, "all1");
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2, "all2");
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 3, "all3");
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 0, "all4");
    // Pointer is 1; serving requester 3 wraps it back to 0.
    applyStimulus(4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1, 3, "wrap");

    // Sparse requesters 1 and 3 alternate.
    applyStimulus(4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1, 1, "alt0");
    applyStimulus(4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1, 3, "alt1");
    applyStimulus(4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1, 1, "alt2");
    applyStimulus(4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1, 3, "alt3");

    // Load id 2, stall three cycles, then resume from requester 3.
    applyStimulus(4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 2, "ld2");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, -1, "stall");
    end
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 3, "resume");

    // Requester 0 streams; requester 2 joins and is not starved.
    applyStimulus(4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 0, "str0");
    applyStimulus(4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 0, "str1");
    applyStimulus(4'b0101, 1'b1, 1'b0, 4'b0100, 1'b1, 2, "str2");
    applyStimulus(4'b0101, 1'b1, 1'b0, 4'b0001, 1'b1, 0, "str3");
    applyStimulus(4'b0101, 1'b1, 1'b0, 4'b0100, 1'b1, 2, "str4");

    // Load a beat, then reset discards it and the pointer returns to 0.
    applyStimulus(4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, -1, "preRst");
    applyStimulus(4'b0100, 1'b1, 1'b1, 4'b0000, 1'b1, -1, "inRst");
    applyStimulus(4'b1010, 1'b1, 1'b0, 4'b0010, 1'b0, 1, "postRst");
    applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, -1, "drain0");
    applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "drain1");

    // Every queued beat must have come out.
    waitCycles = 0;
    while (sb.size() != 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    checkOutput("end", "sb_left", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
